// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: register map,
// CTRL/STATUS bit positions, FSM state encoding and length clamping.
package led_seq_pkg;

  localparam int LED_WIDTH_DEF = 18;

  localparam logic [3:0] ADDR_CTRL       = 4'd0;
  localparam logic [3:0] ADDR_PERIOD     = 4'd1;
  localparam logic [3:0] ADDR_LENGTH     = 4'd2;
  localparam logic [3:0] ADDR_STATUS     = 4'd3;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_ONESHOT_BIT  = 1;
  localparam int CTRL_CLR_BIT      = 2;

  localparam int STAT_BUSY_BIT     = 0;
  localparam int STAT_IDX_LSB      = 8;
  localparam int STAT_DONE_BIT     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CLEAR = 2'd3
  } seq_state_e;

  // Effective sequence length: LENGTH clamped into 1..depth.
  function automatic logic [3:0] length_eff(input logic [31:0] len,
                                            input logic [3:0]  depth);
    logic [3:0] res;
    if (len == 32'd0) begin
      res = 4'd1;
    end else if (len > {28'd0, depth}) begin
      res = depth;
    end else begin
      res = len[3:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/led_seq_regs.sv
// CPU-visible register file: CTRL/PERIOD/LENGTH, sticky DONE, pattern
// table and the zero-wait-state read mux. Also decodes start/stop.
module led_seq_regs
  import led_seq_pkg::*;
#(
  parameter int LED_WIDTH = LED_WIDTH_DEF,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           s_address,
  input  logic                 s_chipselect,
  input  logic                 s_write_n,
  input  logic [31:0]          s_writedata,
  output logic [31:0]          s_readdata,
  input  logic                 running,
  input  logic [2:0]           seq_index,
  input  logic                 done_set,
  input  logic [2:0]           tbl_rd_idx,
  output logic [LED_WIDTH-1:0] tbl_rd_data,
  output logic                 ctrl_oneshot,
  output logic                 ctrl_clr,
  output logic [CNT_WIDTH-1:0] period,
  output logic [31:0]          length,
  output logic                 start,
  output logic                 stop,
  output logic                 stop_clr
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  logic                 en_r;
  logic                 oneshot_r;
  logic                 clr_r;
  logic                 done_r;
  logic [CNT_WIDTH-1:0] period_r;
  logic [31:0]          length_r;
  logic [LED_WIDTH-1:0] table_r [DEPTH];

  logic        wr_s;
  logic        ctrl_wr_s;
  logic        tbl_hit_s;
  logic [31:0] rdata_s;

  assign wr_s      = s_chipselect && !s_write_n;
  assign ctrl_wr_s = wr_s && (s_address == ADDR_CTRL);
  assign tbl_hit_s = s_address[3] && ({1'b0, s_address[2:0]} < DEPTH_L);

  // Start only from IDLE; EN=0 while running is a stop request. The
  // CLR_ON_STOP bit of the same write decides whether a clear is issued.
  assign start    = ctrl_wr_s &&  s_writedata[CTRL_EN_BIT] && !running;
  assign stop     = ctrl_wr_s && !s_writedata[CTRL_EN_BIT] &&  running;
  assign stop_clr = s_writedata[CTRL_CLR_BIT];

  assign ctrl_oneshot = oneshot_r;
  assign ctrl_clr     = clr_r;
  assign period       = period_r;
  assign length       = length_r;
  assign tbl_rd_data  = table_r[tbl_rd_idx[IDX_W-1:0]];
  assign s_readdata   = rdata_s;

  // Control/config registers; one-shot completion overrides a same-cycle EN write.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_r      <= 1'b0;
      oneshot_r <= 1'b0;
      clr_r     <= 1'b0;
      done_r    <= 1'b0;
      period_r  <= {CNT_WIDTH{1'b0}};
      length_r  <= 32'd0;
    end else begin
      if (done_set) begin
        en_r <= 1'b0;
      end else if (ctrl_wr_s) begin
        en_r <= s_writedata[CTRL_EN_BIT];
      end
      if (ctrl_wr_s) begin
        oneshot_r <= s_writedata[CTRL_ONESHOT_BIT];
        clr_r     <= s_writedata[CTRL_CLR_BIT];
      end
      if (start) begin
        done_r <= 1'b0;
      end else if (done_set) begin
        done_r <= 1'b1;
      end
      if (wr_s && (s_address == ADDR_PERIOD)) begin
        period_r <= s_writedata[CNT_WIDTH-1:0];
      end
      if (wr_s && (s_address == ADDR_LENGTH)) begin
        length_r <= s_writedata;
      end
    end
  end

  // Pattern table storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= {LED_WIDTH{1'b0}};
      end
    end else if (wr_s && tbl_hit_s) begin
      table_r[s_address[IDX_W-1:0]] <= s_writedata[LED_WIDTH-1:0];
    end
  end

  // Combinational read mux; unused bits and unmapped addresses read zero.
  always_comb begin
    rdata_s = 32'd0;
    case (s_address)
      ADDR_CTRL: begin
        rdata_s[CTRL_EN_BIT]      = en_r;
        rdata_s[CTRL_ONESHOT_BIT] = oneshot_r;
        rdata_s[CTRL_CLR_BIT]     = clr_r;
      end
      ADDR_PERIOD: rdata_s[CNT_WIDTH-1:0] = period_r;
      ADDR_LENGTH: rdata_s = length_r;
      ADDR_STATUS: begin
        rdata_s[STAT_BUSY_BIT]                  = running;
        rdata_s[STAT_IDX_LSB+2:STAT_IDX_LSB]    = seq_index;
        rdata_s[STAT_DONE_BIT]                  = done_r;
      end
      default: begin
        if (tbl_hit_s) begin
          rdata_s[LED_WIDTH-1:0] = table_r[s_address[IDX_W-1:0]];
        end else begin
          rdata_s = 32'd0;
        end
      end
    endcase
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Autonomous LED pattern player: steps through the pattern table and
// writes each entry to the LED PIO at a programmable cycle interval.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int LED_WIDTH = LED_WIDTH_DEF,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  output logic        busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_TWO  = CNT_WIDTH'(2);
  localparam logic [3:0]           DEPTH_L  = 4'(DEPTH);

  seq_state_e           state_r, state_nxt_s;
  logic [2:0]           index_r, index_nxt_s, step_idx_s;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_nxt_s;
  logic                 done_set_s;
  logic                 m_cs_r, m_wn_r, busy_r;
  logic [LED_WIDTH-1:0] m_wdata_r;

  logic                 running_s;
  logic [LED_WIDTH-1:0] tbl_rd_data_s;
  logic                 oneshot_s, clr_s, start_s, stop_s, stop_clr_s;
  logic [CNT_WIDTH-1:0] period_s, period_eff_s;
  logic [31:0]          length_s;
  logic [3:0]           len_eff_s;
  logic                 last_idx_s;

  assign running_s    = (state_r != ST_IDLE);
  assign period_eff_s = (period_s == CNT_ZERO) ? CNT_ONE : period_s;
  assign len_eff_s    = length_eff(length_s, DEPTH_L);
  // ">=" so a LENGTH shrink below the current index still wraps to 0.
  assign last_idx_s   = ({1'b0, index_r} >= (len_eff_s - 4'd1));
  assign step_idx_s   = last_idx_s ? 3'd0 : (index_r + 3'd1);

  led_seq_regs #(
    .LED_WIDTH (LED_WIDTH),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_regs (
    .clk          (clk),
    .reset        (reset),
    .s_address    (s_address),
    .s_chipselect (s_chipselect),
    .s_write_n    (s_write_n),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .running      (running_s),
    .seq_index    (index_r),
    .done_set     (done_set_s),
    .tbl_rd_idx   (index_nxt_s),
    .tbl_rd_data  (tbl_rd_data_s),
    .ctrl_oneshot (oneshot_s),
    .ctrl_clr     (clr_s),
    .period       (period_s),
    .length       (length_s),
    .start        (start_s),
    .stop         (stop_s),
    .stop_clr     (stop_clr_s)
  );

  // FSM, index and period counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      index_r <= 3'd0;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      index_r <= index_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; a stop request takes priority over any step.
  always_comb begin
    state_nxt_s = state_r;
    index_nxt_s = index_r;
    cnt_nxt_s   = cnt_r;
    done_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_WRITE;
          index_nxt_s = 3'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (stop_s) begin
          state_nxt_s = stop_clr_s ? ST_CLEAR : ST_IDLE;
          index_nxt_s = 3'd0;
        end else if (oneshot_s && last_idx_s) begin
          done_set_s  = 1'b1;
          state_nxt_s = clr_s ? ST_CLEAR : ST_IDLE;
          index_nxt_s = 3'd0;
        end else if (period_eff_s == CNT_ONE) begin
          state_nxt_s = ST_WRITE;
          index_nxt_s = step_idx_s;
        end else begin
          // WAIT lasts PERIODeff-1 cycles: counts PERIODeff-2 down to 0.
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = period_eff_s - CNT_TWO;
        end
      end
      ST_WAIT: begin
        if (stop_s) begin
          state_nxt_s = stop_clr_s ? ST_CLEAR : ST_IDLE;
          index_nxt_s = 3'd0;
        end else if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_WRITE;
          index_nxt_s = step_idx_s;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_CLEAR: begin
        state_nxt_s = ST_IDLE;
        index_nxt_s = 3'd0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        index_nxt_s = 3'd0;
      end
    endcase
  end

  // Registered master port, loaded from the state being entered; data holds when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_cs_r    <= 1'b0;
      m_wn_r    <= 1'b1;
      m_wdata_r <= {LED_WIDTH{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      case (state_nxt_s)
        ST_WRITE: begin
          m_cs_r    <= 1'b1;
          m_wn_r    <= 1'b0;
          m_wdata_r <= tbl_rd_data_s;
        end
        ST_CLEAR: begin
          m_cs_r    <= 1'b1;
          m_wn_r    <= 1'b0;
          m_wdata_r <= {LED_WIDTH{1'b0}};
        end
        default: begin
          m_cs_r <= 1'b0;
          m_wn_r <= 1'b1;
        end
      endcase
    end
  end

  assign m_address    = 2'd0;
  assign m_chipselect = m_cs_r;
  assign m_write_n    = m_wn_r;
  assign m_writedata  = {{(32-LED_WIDTH){1'b0}}, m_wdata_r};
  assign busy         = busy_r;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed self-checking bench for led_pattern_sequencer.
module tb_led_pattern_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  s_address = 4'd0;
  logic        s_chipselect = 1'b0;
  logic        s_write_n = 1'b1;
  logic [31:0] s_writedata = 32'd0;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  logic [31:0] log_data[$];
  int          log_cyc[$];

  led_pattern_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .s_address    (s_address),
    .s_chipselect (s_chipselect),
    .s_write_n    (s_write_n),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Record every PIO write seen mid-cycle, with its cycle number.
  always @(negedge clk) begin
    if (m_chipselect === 1'b1 && m_write_n === 1'b0) begin
      log_data.push_back(m_writedata);
      log_cyc.push_back(cyc_n);
    end
    cyc_n <= cyc_n + 1;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic slave_write(input logic [3:0] addr, input logic [31:0] data);
    tick();
    s_address = addr; s_writedata = data; s_chipselect = 1'b1; s_write_n = 1'b0;
    tick();
    s_chipselect = 1'b0; s_write_n = 1'b1;
  endtask

  task automatic read_reg(input logic [3:0] addr, output logic [31:0] data);
    s_address = addr;
    #1;
    data = s_readdata;
  endtask

  task automatic clear_log();
    log_data.delete();
    log_cyc.delete();
  endtask

  // Compare logged writes against expected data and a fixed spacing.
  task automatic check_log(input string name, input logic [31:0] exp[$], input int gap);
    checks++;
    if (log_data.size() !== exp.size()) begin
      failures++;
      $display("FAIL %s count: got %0d expected %0d", name, log_data.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < log_data.size(); i++) begin
      checks++;
      if (log_data[i] !== exp[i]) begin
        failures++;
        $display("FAIL %s data[%0d]: got %h expected %h", name, i, log_data[i], exp[i]);
      end
      if (i > 0 && gap > 0) begin
        checks++;
        if (log_cyc[i] - log_cyc[i-1] !== gap) begin
          failures++;
          $display("FAIL %s gap[%0d]: got %0d expected %0d", name, i, log_cyc[i] - log_cyc[i-1], gap);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    checks++;
    if (m_chipselect !== 1'b0 || m_write_n !== 1'b1 || m_writedata !== 32'd0 ||
        busy !== 1'b0 || m_address !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs: got cs=%b wn=%b wd=%h busy=%b addr=%0d expected 0 1 0 0 0",
               m_chipselect, m_write_n, m_writedata, busy, m_address);
    end
    for (int a = 0; a < 16; a++) begin
      read_reg(4'(a), rd);
      checks++;
      if (rd !== 32'd0) begin
        failures++;
        $display("FAIL reset_read[%0d]: got %h expected 0", a, rd);
      end
    end
  endtask

  task automatic test_loop();
    logic [31:0] exp[$];
    slave_write(4'd8, 32'h00001);
    slave_write(4'd9, 32'h00002);
    slave_write(4'd10, 32'h3FFFF);
    slave_write(4'd2, 32'd3);
    slave_write(4'd1, 32'd4);
    clear_log();
    slave_write(4'd0, 32'h1);
    checks++;
    if (m_chipselect !== 1'b1 || m_write_n !== 1'b0 || m_writedata !== 32'h1) begin
      failures++;
      $display("FAIL loop_first_write: got cs=%b wn=%b wd=%h expected 1 0 00000001",
               m_chipselect, m_write_n, m_writedata);
    end
    tick(16);
    slave_write(4'd0, 32'h0);
    tick(10);
    exp = '{32'h1, 32'h2, 32'h3FFFF, 32'h1, 32'h2};
    check_log("loop", exp, 4);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL loop_stop_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] exp[$];
    logic [31:0] rd;
    clear_log();
    slave_write(4'd0, 32'h3);
    tick(12);
    exp = '{32'h1, 32'h2, 32'h3FFFF};
    check_log("oneshot", exp, 4);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_busy: got %b expected 0", busy);
    end
    read_reg(4'd3, rd);
    checks++;
    if (rd !== 32'h10000) begin
      failures++;
      $display("FAIL oneshot_status: got %h expected 00010000", rd);
    end
    read_reg(4'd0, rd);
    checks++;
    if (rd !== 32'h2) begin
      failures++;
      $display("FAIL oneshot_ctrl: got %h expected 00000002", rd);
    end
    checks++;
    if (m_writedata !== 32'h3FFFF) begin
      failures++;
      $display("FAIL oneshot_hold: got %h expected 0003ffff", m_writedata);
    end
  endtask

  task automatic test_stop_clear();
    logic [31:0] exp[$];
    slave_write(4'd1, 32'd10);
    clear_log();
    slave_write(4'd0, 32'h1);
    tick(4);
    slave_write(4'd0, 32'h4);
    checks++;
    if (m_chipselect !== 1'b1 || m_write_n !== 1'b0 || m_writedata !== 32'h0) begin
      failures++;
      $display("FAIL stop_clear_write: got cs=%b wn=%b wd=%h expected 1 0 00000000",
               m_chipselect, m_write_n, m_writedata);
    end
    tick(15);
    exp = '{32'h1, 32'h0};
    check_log("stop_clear", exp, 6);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_clear_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_table_update();
    logic [31:0] exp[$];
    slave_write(4'd8, 32'h1);
    slave_write(4'd9, 32'h2);
    slave_write(4'd2, 32'd2);
    slave_write(4'd1, 32'd6);
    clear_log();
    slave_write(4'd0, 32'h1);
    slave_write(4'd9, 32'h155);
    tick(8);
    slave_write(4'd8, 32'h2AA);
    checks++;
    if (m_chipselect !== 1'b1 || m_writedata !== 32'h1) begin
      failures++;
      $display("FAIL same_cycle_step: got cs=%b wd=%h expected 1 00000001", m_chipselect, m_writedata);
    end
    tick(14);
    slave_write(4'd0, 32'h0);
    exp = '{32'h1, 32'h155, 32'h1, 32'h155, 32'h2AA};
    check_log("table_update", exp, 6);
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals[8];
    logic [31:0] exp[$];
    vals = '{32'h00011, 32'h00022, 32'h00033, 32'h00044,
             32'h00055, 32'h00066, 32'h00077, 32'h3FF88};
    for (int i = 0; i < 8; i++) slave_write(4'(8 + i), vals[i]);
    slave_write(4'd1, 32'd0);
    slave_write(4'd2, 32'd0);
    tick(2);
    clear_log();
    slave_write(4'd0, 32'h1);
    tick(9);
    slave_write(4'd0, 32'h0);
    exp.delete();
    for (int i = 0; i < 11; i++) exp.push_back(32'h00011);
    check_log("b2b_len0", exp, 1);
    slave_write(4'd2, 32'd20);
    tick(2);
    clear_log();
    slave_write(4'd0, 32'h1);
    tick(15);
    slave_write(4'd0, 32'h0);
    exp.delete();
    for (int i = 0; i < 17; i++) exp.push_back(vals[i % 8]);
    check_log("b2b_len20", exp, 1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    slave_write(4'd1, 32'd6);
    slave_write(4'd0, 32'h5);
    tick(3);
    reset = 1'b1;
    tick();
    checks++;
    if (m_chipselect !== 1'b0 || m_write_n !== 1'b1 || m_writedata !== 32'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got cs=%b wn=%b wd=%h busy=%b expected 0 1 0 0",
               m_chipselect, m_write_n, m_writedata, busy);
    end
    clear_log();
    reset = 1'b0;
    tick(10);
    checks++;
    if (log_data.size() !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_write: got %0d writes expected 0", log_data.size());
    end
    read_reg(4'd0, rd);
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_ctrl: got %h expected 0", rd);
    end
  endtask

  initial begin
    test_reset();
    test_loop();
    test_oneshot();
    test_stop_clear();
    test_table_update();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
